// File: rtl/fp_div_seq.sv
// -----------------------------------------------------------------------------
// fp_div_seq -- sequential IEEE-754 single-precision divider (z = a / b)
//
// A single operation is in flight at a time. The operands are captured on an
// in_valid/in_ready handshake. Special operands resolve in one step. Normal
// operands go through 26 restoring radix-2 iterations and then rounding. The
// result is held until an out_valid/out_ready handshake. Denormal inputs are
// treated as zero, and results that underflow never become denormals.
//
// Parameters
//   round      rounding mode (fp_div_pkg::round_mode_e), default IEEE_near
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   a, b       dividend / divisor, IEEE-754 single precision
//   in_valid   operands valid
//   in_ready   block idle and able to accept operands
//   z          quotient
//   status     [0] zero [1] inf [2] nan [3] tiny [4] huge [5] inexact
//              [6] div_by_zero [7] always 0
//   out_valid  z/status valid (held until accepted)
//   out_ready  consumer accepts z/status
// -----------------------------------------------------------------------------
package fp_div_pkg;
    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_mode_e;
endpackage

module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter round_mode_e round = IEEE_near
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] z,
    output logic [7:0]  status,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, ROUND, DONE} state_e;

    // Increment decision for the 24-bit mantissa given its lsb and the
    // guard/round/sticky bits below it.
    function automatic logic round_inc(input round_mode_e mode, input logic sign,
                                       input logic lsb, input logic g,
                                       input logic r, input logic s);
        logic lost;
        lost = g | r | s;
        case (mode)
            IEEE_near: round_inc = g & (r | s | lsb);
            IEEE_zero: round_inc = 1'b0;
            IEEE_pinf: round_inc = ~sign & lost;
            IEEE_ninf: round_inc = sign & lost;
            near_up:   round_inc = g;
            away_zero: round_inc = lost;
            default:   round_inc = 1'b0;
        endcase
    endfunction

    // Overflow saturates to max normal instead of infinity when the mode
    // rounds toward zero for that sign.
    function automatic logic ovf_to_max(input round_mode_e mode, input logic sign);
        case (mode)
            IEEE_zero: ovf_to_max = 1'b1;
            IEEE_pinf: ovf_to_max = sign;
            IEEE_ninf: ovf_to_max = ~sign;
            default:   ovf_to_max = 1'b0;
        endcase
    endfunction

    // Underflow lifts to min normal instead of zero when the mode rounds
    // away from zero for that sign.
    function automatic logic unf_to_min(input round_mode_e mode, input logic sign);
        case (mode)
            away_zero: unf_to_min = 1'b1;
            IEEE_pinf: unf_to_min = ~sign;
            IEEE_ninf: unf_to_min = sign;
            default:   unf_to_min = 1'b0;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [23:0]        div_q, div_d;
    logic [25:0]        rem_q, rem_d;
    logic [25:0]        quo_q, quo_d;
    logic [25:0]        cnt_q, cnt_d;      // one-hot iteration marker
    logic [31:0]        z_q, z_d;
    logic [7:0]         status_q, status_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    // Operand unpacking
    logic [7:0]         ea, eb;
    logic [23:0]        ma, mb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_ab;
    logic signed [9:0]  exp_diff;

    always_comb begin
        ea       = a_q[30:23];
        eb       = b_q[30:23];
        ma       = {1'b1, a_q[22:0]};
        mb       = {1'b1, b_q[22:0]};
        a_zero   = (ea == 8'h00);
        b_zero   = (eb == 8'h00);
        a_inf    = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf    = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan    = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan    = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
        sign_ab  = a_q[31] ^ b_q[31];
        exp_diff = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    end

    // Restoring step and rounding arithmetic
    logic               rem_ge;
    logic [25:0]        rem_sub;
    logic               lsb, guard, rnd, sticky, inc;
    logic [24:0]        mant_sum;
    logic [22:0]        frac_fin;
    logic signed [9:0]  exp_fin;
    logic               ovf, unf;

    always_comb begin
        rem_ge   = (rem_q >= {2'b00, div_q});
        rem_sub  = rem_q - {2'b00, div_q};
        lsb      = quo_q[2];
        guard    = quo_q[1];
        rnd      = quo_q[0];
        sticky   = |rem_q;
        inc      = round_inc(round, sign_q, lsb, guard, rnd, sticky);
        mant_sum = {1'b0, quo_q[25:2]} + {24'd0, inc};
        // Rounding carry out of 1.111..1 gives 10.000..0: renormalise.
        if (mant_sum[24]) begin
            frac_fin = mant_sum[23:1];
            exp_fin  = exp_q + 10'sd1;
        end else begin
            frac_fin = mant_sum[22:0];
            exp_fin  = exp_q;
        end
        ovf = (exp_fin >= 10'sd255);
        unf = (exp_fin <= 10'sd0);
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        div_d       = div_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        z_d         = z_q;
        status_d    = status_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sign_d = sign_ab;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    z_d      = 32'h7FC0_0000;
                    status_d = 8'h04;
                    state_d  = DONE;
                end else if (a_inf) begin
                    z_d      = {sign_ab, 8'hFF, 23'd0};
                    status_d = 8'h02;
                    state_d  = DONE;
                end else if (b_zero) begin
                    z_d      = {sign_ab, 8'hFF, 23'd0};
                    status_d = 8'h42;
                    state_d  = DONE;
                end else if (a_zero || b_inf) begin
                    z_d      = {sign_ab, 31'd0};
                    status_d = 8'h01;
                    state_d  = DONE;
                end else begin
                    div_d = mb;
                    quo_d = 26'd0;
                    cnt_d = 26'd1;
                    // Pre-scale the dividend so the quotient lands in [1,2).
                    if (ma < mb) begin
                        rem_d = {1'b0, ma, 1'b0};
                        exp_d = exp_diff - 10'sd1;
                    end else begin
                        rem_d = {2'b00, ma};
                        exp_d = exp_diff;
                    end
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if (rem_ge) begin
                    rem_d = {rem_sub[24:0], 1'b0};
                    quo_d = {quo_q[24:0], 1'b1};
                end else begin
                    rem_d = {rem_q[24:0], 1'b0};
                    quo_d = {quo_q[24:0], 1'b0};
                end
                cnt_d = {cnt_q[24:0], 1'b0};
                if (cnt_q[25]) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                status_d    = 8'h00;
                status_d[5] = guard | rnd | sticky;
                if (ovf) begin
                    status_d[4] = 1'b1;
                    status_d[5] = 1'b1;
                    if (ovf_to_max(round, sign_q)) begin
                        z_d = {sign_q, 31'h7F7F_FFFF};
                    end else begin
                        z_d         = {sign_q, 8'hFF, 23'd0};
                        status_d[1] = 1'b1;
                    end
                end else if (unf) begin
                    status_d[3] = 1'b1;
                    status_d[5] = 1'b1;
                    if (unf_to_min(round, sign_q)) begin
                        z_d = {sign_q, 31'h0080_0000};
                    end else begin
                        z_d         = {sign_q, 31'd0};
                        status_d[0] = 1'b1;
                    end
                end else begin
                    z_d = {sign_q, exp_fin[7:0], frac_fin};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            sign_q      <= 1'b0;
            exp_q       <= 10'sd0;
            div_q       <= 24'd0;
            rem_q       <= 26'd0;
            quo_q       <= 26'd0;
            cnt_q       <= 26'd0;
            z_q         <= 32'd0;
            status_q    <= 8'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign status    = status_q;

endmodule
